// File: rtl/counter_sweep_pkg.sv
// Shared types and constants for the counter sweep sequencer.
// Mode 10 is ping-pong only when COUNTER_SWEEP_PINGPONG_EN is defined.
package counter_sweep_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [MODE_W-1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_WRAP     = 2'b01;
  localparam logic [MODE_W-1:0] MODE_PINGPONG = 2'b10;

  // Fold unsupported/reserved encodings onto one-shot at capture time.
  function automatic logic [MODE_W-1:0] eff_mode(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    r = MODE_ONESHOT;
    if (m == MODE_WRAP) r = MODE_WRAP;
`ifdef COUNTER_SWEEP_PINGPONG_EN
    if (m == MODE_PINGPONG) r = MODE_PINGPONG;
`endif
    return r;
  endfunction

endpackage

// File: rtl/counter_sweep_ctrl_prescaler.sv
// Step prescaler: down-counter that flags a tick at zero and reloads the divider.
module sweep_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div;
    end else if (i_run) begin
      r_cnt <= o_tick ? i_div : r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer driving an up/down counter's control pins (one-shot/wrap/ping-pong).
// Ping-pong mode is built only when COUNTER_SWEEP_PINGPONG_EN is defined.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic [1:0]       cmd_mode,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic             cnt_oe,
  output logic [WIDTH-1:0] cnt_d,
  output logic             busy,
  output logic             done
);

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_start, r_end, r_target, w_target_nxt;
  logic [MODE_W-1:0] r_mode;
  logic [DIV_W-1:0]  r_div;
  logic              r_dir, w_dir_nxt;
  logic              w_tick, w_ps_clr, w_ps_load, w_ps_run;

  sweep_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_ps_clr),
    .i_load (w_ps_load),
    .i_run  (w_ps_run),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_dir    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_dir    <= w_dir_nxt;
    end
  end

  // Command fields are only sampled on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start <= '0;
      r_end   <= '0;
      r_mode  <= MODE_ONESHOT;
      r_div   <= '0;
    end else if (cmd_valid && (r_state == IDLE)) begin
      r_start <= cmd_start;
      r_end   <= cmd_end;
      r_mode  <= eff_mode(cmd_mode);
      r_div   <= cmd_div;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_dir_nxt    = r_dir;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_up       = 1'b0;
    cnt_d        = '0;
    done         = 1'b0;
    w_ps_clr     = 1'b0;
    w_ps_load    = 1'b0;
    w_ps_run     = 1'b0;

    case (r_state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        w_ps_clr  = 1'b1;
        if (cmd_valid) begin
          w_state_nxt  = LOAD;
          w_target_nxt = cmd_end;
          w_dir_nxt    = (cmd_end >= cmd_start);
        end
      end
      LOAD: begin
        cnt_load    = 1'b1;
        cnt_d       = r_start;
        w_ps_load   = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        cnt_up   = r_dir;
        w_ps_run = 1'b1;
        if (w_tick) begin
          if (cnt_q != r_target) begin
            cnt_en = 1'b1;
          end else begin
            case (r_mode)
              MODE_WRAP: begin
                cnt_load = 1'b1;
                cnt_d    = r_start;
              end
`ifdef COUNTER_SWEEP_PINGPONG_EN
              // Turn around at the target and take the first step back immediately.
              MODE_PINGPONG: begin
                if (r_start != r_end) begin
                  w_target_nxt = (r_target == r_end) ? r_start : r_end;
                  w_dir_nxt    = ~r_dir;
                  cnt_up       = ~r_dir;
                  cnt_en       = 1'b1;
                end
              end
`endif
              default: w_state_nxt = FINISH;
            endcase
          end
        end
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Abort leaves the counter holding its current value.
    if (abort && (r_state != IDLE)) begin
      cnt_en      = 1'b0;
      cnt_load    = 1'b0;
      done        = 1'b0;
      w_state_nxt = IDLE;
    end
    if (!rst_n) begin
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
    end
    cnt_oe = busy;
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl with a behavioural 8-bit counter attached.
module tb_counter_sweep_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start, cmd_end;
  logic [1:0]       cmd_mode;
  logic [DIV_W-1:0] cmd_div;
  logic             abort;
  logic [WIDTH-1:0] cnt_q = '0;
  logic             cnt_en, cnt_load, cnt_up, cnt_oe;
  logic [WIDTH-1:0] cnt_d;
  logic             busy, done;

  int total = 0;
  int bad   = 0;

  counter_sweep_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_mode  (cmd_mode),
    .cmd_div   (cmd_div),
    .abort     (abort),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_load  (cnt_load),
    .cnt_up    (cnt_up),
    .cnt_oe    (cnt_oe),
    .cnt_d     (cnt_d),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // The counter being controlled.
  always @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: 0 one-shot, 1 wrap, 2 ping-pong.
  function automatic int model_mode(input int m);
`ifdef COUNTER_SWEEP_PINGPONG_EN
    if (m == 2) return 2;
`endif
    return (m == 1) ? 1 : 0;
  endfunction

  // Ticks land at cycles 2+div, 2+div+(div+1), ... after the accept cycle.
  function automatic int ticks_before(input int c, input int dv);
    int x;
    x = c - 2 - dv;
    return (x <= 0) ? 0 : (x + dv) / (dv + 1);
  endfunction

  function automatic bit is_tick(input int c, input int dv);
    return (c >= 2 + dv) && (((c - 2 - dv) % (dv + 1)) == 0);
  endfunction

  // Distance from start after t ticks.
  function automatic int offset(input int em, input int n, input int t);
    int p;
    if (em == 0) return (t < n) ? t : n;
    if (em == 1) return t % (n + 1);
    if (n == 0) return 0;
    p = t % (2 * n);
    return (p <= n) ? p : 2 * n - p;
  endfunction

  function automatic int exp_q(input int s, input bit dir, input int em, input int n, input int t);
    int v;
    v = dir ? s + offset(em, n, t) : s - offset(em, n, t);
    return v & 255;
  endfunction

  // Issue one command at cycle 0 and check every following cycle against the model.
  task automatic sweep(input int s, input int e, input int m, input int dv,
                       input int max_cyc, input int abort_at, input bit abort_idle,
                       output int done_cyc);
    int n, em, dd, t, p, tq;
    bit dir, tk, en_x, ld_x, busy_x, up_x, done_x, aborted;
    dir = (e >= s);
    n   = dir ? e - s : s - e;
    em  = model_mode(m);
    dd  = 2 + dv + n * (dv + 1) + 1;
    cmd_start = WIDTH'(s);
    cmd_end   = WIDTH'(e);
    cmd_mode  = 2'(m);
    cmd_div   = DIV_W'(dv);
    cmd_valid = 1'b1;
    abort     = abort_idle;
    @(negedge clk);
    chk("accept_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    done_cyc  = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      abort   = (c == abort_at);
      aborted = (abort_at > 0) && (c > abort_at);
      t  = ticks_before(c, dv);
      tk = is_tick(c, dv);
      busy_x = (em == 0) ? (c <= dd) : 1'b1;
      if (aborted) busy_x = 1'b0;
      ld_x = (c == 1);
      en_x = 1'b0;
      up_x = dir;
      if (c >= 2 && tk && (em != 0 || c < dd)) begin
        case (em)
          0: en_x = (t < n);
          1: begin en_x = ((t % (n + 1)) != n); ld_x = !en_x; end
          default: begin
            en_x = (n != 0);
            p    = (n == 0) ? 0 : t % (2 * n);
            up_x = (p < n) ? dir : !dir;
          end
        endcase
      end
      if (c == abort_at || aborted) begin en_x = 1'b0; ld_x = 1'b0; end
      done_x = (em == 0) && (c == dd) && (c != abort_at) && !aborted;
      tq = aborted ? ticks_before(abort_at, dv) : t;
      @(negedge clk);
      chk("busy", int'(busy), int'(busy_x));
      chk("ready", int'(cmd_ready), int'(!busy_x));
      chk("oe", int'(cnt_oe), int'(busy_x));
      chk("done", int'(done), int'(done_x));
      chk("load", int'(cnt_load), int'(ld_x));
      chk("en", int'(cnt_en), int'(en_x));
      if (en_x) chk("up", int'(cnt_up), int'(up_x));
      if (ld_x) chk("cnt_d", int'(cnt_d), s);
      if (c >= 2) chk("cnt_q", int'(cnt_q), exp_q(s, dir, em, n, tq));
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  typedef struct {
    int s; int e; int m; int dv; int exp_done; int exp_q;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int dc, s, e, m, dv, delta, n, dd, a, mx;
    bit ai;

    tbl.push_back('{3,   5,   0, 0, 5,   5});
    tbl.push_back('{10,  7,   0, 2, 14,  7});
    tbl.push_back('{7,   7,   0, 0, 3,   7});
    tbl.push_back('{2,   4,   3, 1, 8,   4});
    tbl.push_back('{9,   5,   3, 0, 7,   5});
    tbl.push_back('{0,   255, 0, 0, 258, 255});
`ifndef COUNTER_SWEEP_PINGPONG_EN
    tbl.push_back('{250, 255, 2, 0, 8,   255});
`endif

    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_start = '0; cmd_end = '0; cmd_mode = '0; cmd_div = '0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ctl", int'({cnt_en, cnt_load, cnt_up, cnt_oe, done}), 0);
    chk("rst_d", int'(cnt_d), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed one-shot table: done cycle and settled counter value.
    foreach (tbl[i]) begin
      sweep(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].dv, tbl[i].exp_done + 1, -1, 1'b0, dc);
      chk($sformatf("tbl%0d_done_cyc", i), dc, tbl[i].exp_done);
      chk($sformatf("tbl%0d_final_q", i), int'(cnt_q), tbl[i].exp_q);
    end

    // Wrap 0->2 then abort; ping-pong across the top of the range; hold with start==end.
    sweep(0, 2, 1, 0, 11, 10, 1'b0, dc);
    chk("wrap_no_done", dc, -1);
`ifdef COUNTER_SWEEP_PINGPONG_EN
    sweep(250, 255, 2, 0, 26, 25, 1'b0, dc);
    chk("pp_no_done", dc, -1);
    sweep(7, 7, 2, 0, 9, 8, 1'b0, dc);
    chk("pp_hold_no_done", dc, -1);
`endif

    // Command held through a sweep is only taken once ready returns.
    cmd_start = 8'd7; cmd_end = 8'd7; cmd_mode = 2'd0; cmd_div = '0;
    cmd_valid = 1'b1;
    @(negedge clk); chk("hold_ready0", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_start = 8'd20;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("hold_ready", int'(cmd_ready), 0);
      if (c == 3) chk("hold_done", int'(done), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hold_ready4", int'(cmd_ready), 1);
    chk("hold_q", int'(cnt_q), 7);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_load", int'(cnt_load), 1);
    chk("hold_d", int'(cnt_d), 20);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk); chk("hold_abort_en", int'(cnt_en), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("hold_abort_busy", int'(busy), 0);
    chk("hold_abort_q", int'(cnt_q), 20);
    @(posedge clk); #1;

    // Reset in the middle of a wrap sweep, on the cycle a reload would happen.
    cmd_start = 8'd0; cmd_end = 8'd2; cmd_mode = 2'd1; cmd_div = '0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_load", int'(cnt_load), 0);
    chk("rst_mid_en", int'(cnt_en), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_q", int'(cnt_q), 2);
    @(posedge clk); #1;

    // Randomised sweeps against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      m     = int'($urandom_range(0, 3));
      dv    = int'($urandom_range(0, 3));
      s     = int'($urandom_range(0, 255));
      delta = int'($urandom_range(0, 10)) - 5;
      e     = s + delta;
      if (e < 0 || e > 255) e = s - delta;
      ai    = 1'($urandom_range(0, 1));
      n     = (e >= s) ? e - s : s - e;
      dd    = 2 + dv + n * (dv + 1) + 1;
      if (model_mode(m) == 0) begin
        a  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, dd)) : -1;
        mx = (a > 0) ? a + 1 : dd + 1;
      end else begin
        a  = int'($urandom_range(2, 30));
        mx = a + 1;
      end
      sweep(s, e, m, dv, mx, a, ai, dc);
      if (model_mode(m) == 0 && a < 0) chk("rnd_done_cyc", dc, dd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer that drives the 8-bit up/down counter's control pins (en, load, up, oe, d) to execute programmed sweeps from a start value to an end value. Sweeps run one-shot, wrapping, or ping-pong, with a programmable step prescaler. The block sits between a command source and the counter instance, and reads the counter's output bus back to detect the end of a sweep.

## Interface
- `WIDTH`, default 8: counter data width.
- `DIV_W`, default 8: prescaler width.
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_start` in WIDTH: first value.
- `cmd_end` in WIDTH: target value.
- `cmd_mode` in 2: 00 one-shot, 01 wrap, 10 ping-pong, 11 treated as one-shot.
- `cmd_div` in DIV_W: one step every `cmd_div+1` cycles.
- `abort` in 1: terminate the sweep.
- `cnt_q` in WIDTH: counter output bus; valid only while `cnt_oe=1`.
- `cnt_en`, `cnt_load`, `cnt_up`, `cnt_oe` out 1 each: counter controls.
- `cnt_d` out WIDTH: counter load value.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a one-shot sweep completes.

## Operation
- States: IDLE, LOAD, RUN, FINISH.
- All command fields are captured on accept and ignored at every other time.
- Direction `dir = (end >= start)`; target register = `end`.
- **IDLE:** `cmd_ready=1`. Accepting a command moves to LOAD.
- **LOAD:** one cycle with `cnt_load=1` and `cnt_d=start`. Moves to RUN. The prescaler is loaded with `div`.
- **RUN:** `cnt_oe=1`. A tick occurs when the prescaler is 0; the prescaler then reloads `div`, otherwise it decrements. On a tick:
  - `cnt_q != target`: `cnt_en=1`, `cnt_up=dir`.
  - `cnt_q == target`, one-shot: go to FINISH with no enable.
  - `cnt_q == target`, wrap: `cnt_load=1`, `cnt_d=start`, stay in RUN.
  - `cnt_q == target`, ping-pong: swap the target between start and end, invert `dir`, and assert `cnt_en=1` with the new `cnt_up` in the same cycle.
- **FINISH:** `done=1` for one cycle, then IDLE.
- `cnt_oe = busy`; `cnt_up` holds `dir` throughout RUN.
- `cnt_en` and `cnt_load` are never high in the same cycle.
- The counter steps by ±1, so it never passes the target. No modular-wrap arithmetic is needed; equality compare only.
- Boundary cases:
  - `start==end`, one-shot: FINISH on the first tick.
  - `start==end`, wrap: reloads on every tick, forever.
  - `start==end`, ping-pong: holds with no enable until abort.
- Abort in LOAD, RUN or FINISH: `cnt_en` and `cnt_load` are forced to 0 combinationally in that cycle. Next state is IDLE, with no `done`. The counter keeps its value.
- Abort in IDLE is ignored. When `abort` and `cmd_valid` are high together in IDLE, the command is accepted.
- Wrap and ping-pong modes run until abort.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, all other outputs 0, `cnt_d=0`, internal registers 0.
- Reset mid-sweep returns to IDLE on the next edge; the counter is not reloaded.
- Example, accept in cycle 0 (start 3, end 5, div 0, one-shot):
  - Cycle 1: LOAD.
  - Cycle 2: RUN with `cnt_q=3`; `cnt_en` high in cycles 2–3.
  - Cycle 4: `cnt_q=5`.
  - Cycle 5: `done=1`.
  - Cycle 6: `cmd_ready=1`.
- With divider `div`, consecutive steps are `div+1` cycles apart. The first tick falls `div` cycles after RUN entry.

## Configuration
- `COUNTER_SWEEP_PINGPONG_EN` defined: mode 10 is ping-pong.
- Not defined: mode 10 behaves as one-shot, and the target-swap logic is not built.

## Structure
- Package `counter_sweep_pkg`: state enum (IDLE/LOAD/RUN/FINISH) and mode constants (MODE_ONESHOT, MODE_WRAP, MODE_PINGPONG).
- Sub-module `sweep_prescaler`: DIV_W down-counter with reload and `tick` output, cleared by a synchronous clear from the FSM.

## Test plan
- Reset with `rst_n=0` for 2 cycles → `cmd_ready=1`; `busy`, `cnt_*` and `done` are all 0.
- One-shot 3→5, div 0 → `cnt_load` in cycle 1, `cnt_en` in cycles 2–3, `done` in cycle 5, `cnt_q` stays 5.
- Down one-shot 10→7, div 2 → `cnt_up=0` and `cnt_en` every 3rd cycle; `done` after `cnt_q=7`.
- Wrap 0→2, div 0 → `cnt_q` sequence 0,1,2,(load)0,1,2…; abort → IDLE next cycle with no `done`.
- Ping-pong 250→255, div 0 → 250…255, 254…250, 251…; `cnt_q` never 0. Without the macro: `done` at 255.
- `start==end=7`, one-shot → `done` in cycle 3 with no `cnt_en`. `cmd_valid` held during RUN → not accepted until `cmd_ready`.
